// File: rtl/mult_result_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_result_buffer_if
// Description : Bundle between the multiplier result buffer and the logic
//               around it. The master side holds the last multiplier
//               stage, the CDB arbiter and the branch-recovery logic. The
//               slave side is the buffer itself.
//   Master -> slave : in_valid, in_product, in_NPC, in_IR, in_dest_tag,
//                     in_b_mask, cdb_grant, recovery_request,
//                     recovery_b_mask, br_correct, br_correct_address
//   Slave -> master : out_valid, out_product, out_NPC, out_IR, out_dest_tag,
//                     out_b_mask, count, issue_stall
// Revision    : 1.0  initial release
// ============================================================================
interface mult_result_buffer_if #(
    parameter int DEPTH     = 12,
    parameter int STACK_NUM = 4,
    parameter int TAG_W     = 7
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BRA_W = $clog2(STACK_NUM);

    logic                 in_valid;
    logic [63:0]          in_product;
    logic [63:0]          in_NPC;
    logic [31:0]          in_IR;
    logic [TAG_W-1:0]     in_dest_tag;
    logic [STACK_NUM-1:0] in_b_mask;
    logic                 cdb_grant;
    logic                 recovery_request;
    logic [STACK_NUM-1:0] recovery_b_mask;
    logic                 br_correct;
    logic [BRA_W-1:0]     br_correct_address;

    logic                 out_valid;
    logic [63:0]          out_product;
    logic [63:0]          out_NPC;
    logic [31:0]          out_IR;
    logic [TAG_W-1:0]     out_dest_tag;
    logic [STACK_NUM-1:0] out_b_mask;
    logic [CNT_W-1:0]     count;
    logic                 issue_stall;

    modport master (
        output in_valid, in_product, in_NPC, in_IR, in_dest_tag, in_b_mask,
               cdb_grant, recovery_request, recovery_b_mask,
               br_correct, br_correct_address,
        input  out_valid, out_product, out_NPC, out_IR, out_dest_tag,
               out_b_mask, count, issue_stall
    );

    modport slave (
        input  in_valid, in_product, in_NPC, in_IR, in_dest_tag, in_b_mask,
               cdb_grant, recovery_request, recovery_b_mask,
               br_correct, br_correct_address,
        output out_valid, out_product, out_NPC, out_IR, out_dest_tag,
               out_b_mask, count, issue_stall
    );
endinterface
`default_nettype wire

// File: rtl/mult_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : mult_result_buffer
// Description : Oldest-first result queue behind the final multiplier stage.
//               Each completed product is captured with its NPC, IR, dest
//               tag and branch mask. The entry is held until the CDB arbiter
//               takes it. Every cycle, branch-recovery squash and
//               branch-correct mask clearing are applied to all queued
//               entries. The multiplier pipeline cannot stall, so
//               issue_stall stops new issues early enough that every
//               result already in flight still has a slot.
// Ports       : clock  - system clock, rising edge
//               reset  - synchronous, active-low
//               bus    - mult_result_buffer_if.slave (incoming result,
//                        CDB grant, recovery/br_correct, head outputs,
//                        count, issue_stall)
// Revision    : 1.0  initial release
// ============================================================================
module mult_result_buffer #(
    parameter int DEPTH     = 12,
    parameter int MULT_LAT  = 8,
    parameter int STACK_NUM = 4,
    parameter int TAG_W     = 7
) (
    input  wire                    clock,
    input  wire                    reset,
    mult_result_buffer_if.slave    bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Storage: entry 0 is always the oldest live entry.
    logic [63:0]          r_product [DEPTH];
    logic [63:0]          r_npc     [DEPTH];
    logic [31:0]          r_ir      [DEPTH];
    logic [TAG_W-1:0]     r_tag     [DEPTH];
    logic [STACK_NUM-1:0] r_mask    [DEPTH];
    logic [CNT_W-1:0]     r_count;

    logic [63:0]          w_nxt_product [DEPTH];
    logic [63:0]          w_nxt_npc     [DEPTH];
    logic [31:0]          w_nxt_ir      [DEPTH];
    logic [TAG_W-1:0]     w_nxt_tag     [DEPTH];
    logic [STACK_NUM-1:0] w_nxt_mask    [DEPTH];
    logic [CNT_W-1:0]     w_nxt_count;

    logic [DEPTH-1:0]     w_squash;
    logic                 w_in_squash;
    logic                 w_head_valid;
    logic                 w_grant;
    logic                 w_overflow;
    logic [CNT_W-1:0]     v_pos;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_squash[i] = bus.recovery_request && (|(r_mask[i] & bus.recovery_b_mask));
        end
        w_in_squash = bus.recovery_request && (|(bus.in_b_mask & bus.recovery_b_mask));
    end

    // A head that is being squashed this cycle is never offered to the CDB.
    // A grant is therefore honoured only when the head is still valid.
    assign w_head_valid = (r_count != '0) && !w_squash[0];
    assign w_grant      = bus.cdb_grant && w_head_valid;

    // Next-state queue: survivors are compacted in age order. The granted
    // head is dropped. The unsquashed incoming result is appended behind
    // the survivors, and then the resolved branch bit is cleared in every
    // mask.
    always_comb begin
        w_nxt_product = '{default: '0};
        w_nxt_npc     = '{default: '0};
        w_nxt_ir      = '{default: '0};
        w_nxt_tag     = '{default: '0};
        w_nxt_mask    = '{default: '0};
        w_overflow    = 1'b0;
        v_pos         = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < r_count) && !w_squash[i] && !((i == 0) && w_grant)) begin
                w_nxt_product[v_pos] = r_product[i];
                w_nxt_npc[v_pos]     = r_npc[i];
                w_nxt_ir[v_pos]      = r_ir[i];
                w_nxt_tag[v_pos]     = r_tag[i];
                w_nxt_mask[v_pos]    = r_mask[i];
                v_pos                = v_pos + CNT_W'(1);
            end
        end

        if (bus.in_valid && !w_in_squash) begin
            if (v_pos < CNT_W'(DEPTH)) begin
                w_nxt_product[v_pos] = bus.in_product;
                w_nxt_npc[v_pos]     = bus.in_NPC;
                w_nxt_ir[v_pos]      = bus.in_IR;
                w_nxt_tag[v_pos]     = bus.in_dest_tag;
                w_nxt_mask[v_pos]    = bus.in_b_mask;
                v_pos                = v_pos + CNT_W'(1);
            end else begin
                w_overflow = 1'b1;
            end
        end

        if (bus.br_correct) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_nxt_mask[i][bus.br_correct_address] = 1'b0;
            end
        end

        w_nxt_count = v_pos;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_product <= '{default: '0};
            r_npc     <= '{default: '0};
            r_ir      <= '{default: '0};
            r_tag     <= '{default: '0};
            r_mask    <= '{default: '0};
            r_count   <= '0;
        end else begin
            r_product <= w_nxt_product;
            r_npc     <= w_nxt_npc;
            r_ir      <= w_nxt_ir;
            r_tag     <= w_nxt_tag;
            r_mask    <= w_nxt_mask;
            r_count   <= w_nxt_count;
            // The issue_stall lookahead should make this impossible. If it
            // happens anyway, the incoming result is lost.
            assert (!w_overflow)
                else $error("mult_result_buffer: append into full queue, result dropped");
        end
    end

    assign bus.out_valid    = w_head_valid;
    assign bus.out_product  = r_product[0];
    assign bus.out_NPC      = r_npc[0];
    assign bus.out_IR       = r_ir[0];
    assign bus.out_dest_tag = r_tag[0];
    assign bus.out_b_mask   = r_mask[0];
    assign bus.count        = r_count;
    // Stall while the results already in the pipeline could fill the queue.
    assign bus.issue_stall  = (int'(r_count) + MULT_LAT) >= DEPTH;
endmodule
`default_nettype wire

// File: tb/tb_mult_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_result_buffer
// Description : Self-checking bench for mult_result_buffer. The reference
//               model is a queue of result records. It is updated with the
//               buffer rules: filter out squashed records, pop the granted
//               head, push the incoming record, and clear the resolved
//               branch bit.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mult_result_buffer;
    localparam int DEPTH     = 12;
    localparam int MULT_LAT  = 8;
    localparam int STACK_NUM = 4;
    localparam int TAG_W     = 7;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mult_result_buffer_if #(.DEPTH(DEPTH), .STACK_NUM(STACK_NUM), .TAG_W(TAG_W)) bus();

    mult_result_buffer #(
        .DEPTH(DEPTH), .MULT_LAT(MULT_LAT), .STACK_NUM(STACK_NUM), .TAG_W(TAG_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [63:0]          p;
        logic [63:0]          npc;
        logic [31:0]          ir;
        logic [TAG_W-1:0]     tag;
        logic [STACK_NUM-1:0] m;
    } ent_t;

    ent_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    function automatic bit sq(input logic [STACK_NUM-1:0] m);
        return bus.recovery_request && ((m & bus.recovery_b_mask) != '0);
    endfunction

    task automatic idle();
        bus.in_valid         = 1'b0;
        bus.cdb_grant        = 1'b0;
        bus.recovery_request = 1'b0;
        bus.recovery_b_mask  = '0;
        bus.br_correct       = 1'b0;
        bus.br_correct_address = '0;
    endtask

    task automatic push_in(input logic [63:0] p, input logic [TAG_W-1:0] tag,
                           input logic [STACK_NUM-1:0] m);
        bus.in_valid    = 1'b1;
        bus.in_product  = p;
        bus.in_NPC      = {$urandom, $urandom};
        bus.in_IR       = $urandom;
        bus.in_dest_tag = tag;
        bus.in_b_mask   = m;
    endtask

    // Called just after a falling edge with the inputs already set. It checks
    // the outputs against the model, steps the model across the rising edge,
    // and returns after the next falling edge with the inputs idle again.
    task automatic cycle();
        ent_t nq[$];
        ent_t e;
        bit   exp_ov;
        #2;
        exp_ov = (q.size() != 0) && !sq(q[0].m);
        chk("count", 64'(bus.count), 64'(q.size()));
        chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
        chk("issue_stall", 64'(bus.issue_stall), 64'((q.size() + MULT_LAT) >= DEPTH));
        if (exp_ov) begin
            chk("out_product", bus.out_product, q[0].p);
            chk("out_NPC", bus.out_NPC, q[0].npc);
            chk("out_IR", 64'(bus.out_IR), 64'(q[0].ir));
            chk("out_dest_tag", 64'(bus.out_dest_tag), 64'(q[0].tag));
            chk("out_b_mask", 64'(bus.out_b_mask), 64'(q[0].m));
        end
        @(posedge clock);
        if (!reset) begin
            q.delete();
        end else begin
            foreach (q[i]) if (!sq(q[i].m)) nq.push_back(q[i]);
            if (bus.cdb_grant && exp_ov) void'(nq.pop_front());
            if (bus.in_valid && !sq(bus.in_b_mask) && nq.size() < DEPTH) begin
                e.p = bus.in_product; e.npc = bus.in_NPC; e.ir = bus.in_IR;
                e.tag = bus.in_dest_tag; e.m = bus.in_b_mask;
                nq.push_back(e);
            end
            if (bus.br_correct) begin
                foreach (nq[i]) begin
                    e = nq[i];
                    e.m[bus.br_correct_address] = 1'b0;
                    nq[i] = e;
                end
            end
            q = nq;
        end
        @(negedge clock);
        idle();
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 40) begin
            bus.cdb_grant = 1'b1;
            cycle();
            guard++;
        end
        #1;
        chk("drain_count", 64'(bus.count), 64'd0);
    endtask

    initial begin
        idle();
        bus.in_product = '0; bus.in_NPC = '0; bus.in_IR = '0;
        bus.in_dest_tag = '0; bus.in_b_mask = '0;

        // 1: reset held low for two edges
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_issue_stall", 64'(bus.issue_stall), 64'd0);
        chk("rst_out_product", bus.out_product, 64'd0);
        @(negedge clock);

        // 2: single result with one-register latency, then grant
        push_in(64'h1234, 7'd5, 4'b0000);
        cycle();
        #1;
        chk("t2_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t2_product", bus.out_product, 64'h1234);
        chk("t2_tag", 64'(bus.out_dest_tag), 64'd5);
        bus.cdb_grant = 1'b1;
        cycle();
        #1;
        chk("t2_count_after_grant", 64'(bus.count), 64'd0);
        @(negedge clock);

        // 3: recovery squashes the middle of three entries
        push_in(64'hA1, 7'd1, 4'b0001); cycle();
        push_in(64'hA2, 7'd2, 4'b0010); cycle();
        push_in(64'hA3, 7'd3, 4'b0100); cycle();
        bus.recovery_request = 1'b1; bus.recovery_b_mask = 4'b0010;
        cycle();
        #1;
        chk("t3_count", 64'(bus.count), 64'd2);
        chk("t3_head", bus.out_product, 64'hA1);
        drain();
        @(negedge clock);

        // 4: br_correct clears bit 0, so a later recovery on bit 0 misses
        push_in(64'hB4, 7'd4, 4'b0011); cycle();
        bus.br_correct = 1'b1; bus.br_correct_address = 2'd0;
        cycle();
        #1;
        chk("t4_mask_cleared", 64'(bus.out_b_mask), 64'b0010);
        @(negedge clock);
        bus.recovery_request = 1'b1; bus.recovery_b_mask = 4'b0001;
        cycle();
        #1;
        chk("t4_survives", 64'(bus.count), 64'd1);
        chk("t4_product", bus.out_product, 64'hB4);
        drain();
        @(negedge clock);

        // 5: issue_stall asserts at DEPTH-MULT_LAT entries
        for (int i = 0; i < DEPTH - MULT_LAT; i++) begin
            push_in(64'hC0 + 64'(i), TAG_W'(i), 4'b0000);
            cycle();
        end
        #1;
        chk("t5_stall_on", 64'(bus.issue_stall), 64'd1);
        @(negedge clock);
        bus.cdb_grant = 1'b1;
        cycle();
        #1;
        chk("t5_stall_off", 64'(bus.issue_stall), 64'd0);
        drain();
        @(negedge clock);

        // 6: head squashed in the same cycle as a grant
        push_in(64'hD1, 7'd11, 4'b0001); cycle();
        push_in(64'hD2, 7'd12, 4'b0010); cycle();
        bus.recovery_request = 1'b1; bus.recovery_b_mask = 4'b0001;
        bus.cdb_grant = 1'b1;
        #1;
        chk("t6_no_offer", 64'(bus.out_valid), 64'd0);
        cycle();
        #1;
        chk("t6_count", 64'(bus.count), 64'd1);
        chk("t6_new_head", bus.out_product, 64'hD2);
        drain();
        @(negedge clock);

        // Random traffic, including mid-traffic resets
        for (int n = 0; n < 400; n++) begin
            if (($urandom_range(0, 3) != 0) && (q.size() < DEPTH))
                push_in({$urandom, $urandom}, TAG_W'($urandom), STACK_NUM'($urandom));
            bus.cdb_grant          = 1'($urandom_range(0, 1));
            bus.recovery_request   = ($urandom_range(0, 9) == 0);
            bus.recovery_b_mask    = STACK_NUM'($urandom);
            bus.br_correct         = ($urandom_range(0, 4) == 0);
            bus.br_correct_address = 2'($urandom);
            reset                  = ($urandom_range(0, 99) != 0);
            cycle();
        end
        reset = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
